mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one shared memory port. Fetch and data requesters
// compete for a single outstanding transaction. Data normally wins, but a
// fetch that has lost MAX_WAIT times in a row is forced through. A wait
// timeout and any unexpected response both raise a sticky error flag.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_mode,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [2:0]  m_mode,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        err
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned MODE_W  = 3;
    localparam int unsigned FWAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned TCNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_F = 2'd1,
        WAIT_D = 2'd2
    } arbState;

    // Request as presented on the memory port.
    typedef struct packed {
        logic              we;
        logic [MODE_W-1:0] mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memReq;

    arbState             state;
    arbState             stateNext;
    logic [FWAIT_W-1:0]  fwait;
    logic [FWAIT_W-1:0]  fwaitNext;
    logic [TCNT_W-1:0]   tcnt;
    logic [TCNT_W-1:0]   tcntNext;
    memReq               mReg;
    memReq               mRegNext;
    logic                mReqNext;
    logic                fRvalidNext;
    logic [DATA_W-1:0]   fRdataNext;
    logic                dRvalidNext;
    logic [DATA_W-1:0]   dRdataNext;
    logic                errNext;
    logic                busyNext;
    logic                grantF;
    logic                grantD;
    logic                fetchStarved;
    logic                waitDone;

    assign m_we    = mReg.we;
    assign m_mode  = mReg.mode;
    assign m_addr  = mReg.addr;
    assign m_wdata = mReg.wdata;
    assign f_gnt   = grantF;
    assign d_gnt   = grantD;

    // Arbitration, response handling, timeout and next-state decode.
    always_comb begin
        stateNext    = state;
        fwaitNext    = fwait;
        tcntNext     = tcnt;
        mRegNext     = mReg;
        mReqNext     = 1'b0;
        fRvalidNext  = 1'b0;
        fRdataNext   = f_rdata;
        dRvalidNext  = 1'b0;
        dRdataNext   = d_rdata;
        errNext      = err;
        grantF       = 1'b0;
        grantD       = 1'b0;
        fetchStarved = (fwait == FWAIT_W'(MAX_WAIT));
        waitDone     = 1'b0;

        case (state)
            IDLE: begin
                // A response with nothing outstanding is a protocol error.
                if (m_rvalid) begin
                    errNext = 1'b1;
                end
                if (!reset) begin
                    if (d_req && !(f_req && fetchStarved)) begin
                        grantD = 1'b1;
                    end else if (f_req) begin
                        grantF = 1'b1;
                    end
                end
                if (grantD) begin
                    stateNext      = WAIT_D;
                    mReqNext       = 1'b1;
                    tcntNext       = '0;
                    mRegNext.we    = d_we;
                    mRegNext.mode  = d_mode;
                    mRegNext.addr  = d_addr;
                    mRegNext.wdata = d_wdata;
                    if (f_req && !fetchStarved) begin
                        fwaitNext = fwait + FWAIT_W'(1);
                    end
                end else if (grantF) begin
                    stateNext      = WAIT_F;
                    mReqNext       = 1'b1;
                    tcntNext       = '0;
                    fwaitNext      = '0;
                    mRegNext.we    = 1'b0;
                    mRegNext.mode  = '0;
                    mRegNext.addr  = f_addr;
                    mRegNext.wdata = '0;
                end
            end

            WAIT_F, WAIT_D: begin
                // The TIMEOUT-th wait cycle without a response ends the wait.
                waitDone = m_rvalid || (tcnt == TCNT_W'(TIMEOUT - 1));
                if (waitDone) begin
                    stateNext = IDLE;
                    tcntNext  = '0;
                    if (!m_rvalid) begin
                        errNext = 1'b1;
                    end
                    if (state == WAIT_F) begin
                        fRvalidNext = 1'b1;
                        fRdataNext  = m_rvalid ? m_rdata : '0;
                    end else begin
                        dRvalidNext = 1'b1;
                        dRdataNext  = (m_rvalid && !mReg.we) ? m_rdata : '0;
                    end
                end else begin
                    tcntNext = tcnt + TCNT_W'(1);
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

    // State, counters and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fwait    <= '0;
            tcnt     <= '0;
            mReg     <= '0;
            m_req    <= 1'b0;
            f_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= stateNext;
            fwait    <= fwaitNext;
            tcnt     <= tcntNext;
            mReg     <= mRegNext;
            m_req    <= mReqNext;
            f_rvalid <= fRvalidNext;
            f_rdata  <= fRdataNext;
            d_rvalid <= dRvalidNext;
            d_rdata  <= dRdataNext;
            busy     <= busyNext;
            err      <= errNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, f_gnt, f_rvalid;
    logic [31:0] f_addr, f_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [2:0]  d_mode;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_rvalid;
    logic [2:0]  m_mode;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        busy, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_mode(m_mode), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .err(err)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs.
    int unsigned fRate = 0, dRate = 0, storePct = 0, spurPct = 0, rstPermille = 0;
    int unsigned minDel = 1, maxDel = 1;
    bit          noResp = 1'b0, rstForce = 1'b1, rdFix = 1'b0;
    logic [31:0] rdVal = '0;

    // Requester and responder state.
    bit          fPend = 1'b0, dPend = 1'b0;
    logic [31:0] fA = '0, dA = '0, dWd = '0;
    logic        dW = 1'b0;
    logic [2:0]  dM = '0;
    int          cyc = 0, respAt = -1;

    // Model: owner 0 = none, 1 = fetch, 2 = data.
    int          owner = 0, waitCnt = 0, losses = 0;
    logic        ownerWe = 1'b0;
    logic        expMReq = 0, expMWe = 0, expFRv = 0, expDRv = 0, expBusy = 0, expErr = 0;
    logic [2:0]  expMMode = '0;
    logic [31:0] expMAddr = '0, expMWdata = '0, expFRd = '0, expDRd = '0;

    // Observation counters used by directed phases.
    int fGntCnt = 0, dGntCnt = 0, dRvCnt = 0;

    task automatic schedResp();
        if (noResp) respAt = -1;
        else respAt = cyc + int'($urandom_range(maxDel, minDel));
    endtask

    task automatic step();
        bit          gF, gD, rv, rstIn;
        logic [31:0] rd;
        @(negedge clk);
        checkEq("m_req",    32'(m_req),    32'(expMReq));
        checkEq("m_we",     32'(m_we),     32'(expMWe));
        checkEq("m_mode",   32'(m_mode),   32'(expMMode));
        checkEq("m_addr",   m_addr,        expMAddr);
        checkEq("m_wdata",  m_wdata,       expMWdata);
        checkEq("f_rvalid", 32'(f_rvalid), 32'(expFRv));
        checkEq("f_rdata",  f_rdata,       expFRd);
        checkEq("d_rvalid", 32'(d_rvalid), 32'(expDRv));
        checkEq("d_rdata",  d_rdata,       expDRd);
        checkEq("busy",     32'(busy),     32'(expBusy));
        checkEq("err",      32'(err),      32'(expErr));
        if (d_rvalid) dRvCnt++;

        cyc++;
        if (!fPend && $urandom_range(99, 0) < fRate) begin
            fPend = 1'b1;
            fA    = $urandom;
        end
        if (!dPend && $urandom_range(99, 0) < dRate) begin
            dPend = 1'b1;
            dW    = ($urandom_range(99, 0) < storePct);
            dM    = 3'($urandom);
            dA    = $urandom;
            dWd   = $urandom;
        end
        rstIn = rstForce || ($urandom_range(999, 0) < rstPermille);
        rd    = rdFix ? rdVal : $urandom;
        rv    = (cyc == respAt);
        if (owner == 0 && $urandom_range(99, 0) < spurPct) rv = 1'b1;

        reset    = rstIn;
        f_req    = fPend;
        f_addr   = fA;
        d_req    = dPend;
        d_we     = dW;
        d_mode   = dM;
        d_addr   = dA;
        d_wdata  = dWd;
        m_rvalid = rv;
        m_rdata  = rd;

        gF = 1'b0;
        gD = 1'b0;
        if (!rstIn && owner == 0) begin
            if (dPend && !(fPend && losses == int'(MAX_WAIT))) gD = 1'b1;
            else if (fPend) gF = 1'b1;
        end
        #1;
        checkEq("f_gnt", 32'(f_gnt), 32'(gF));
        checkEq("d_gnt", 32'(d_gnt), 32'(gD));
        if (f_gnt) fGntCnt++;
        if (d_gnt) dGntCnt++;

        expMReq = 1'b0;
        expFRv  = 1'b0;
        expDRv  = 1'b0;
        if (rstIn) begin
            owner = 0; waitCnt = 0; losses = 0;
            expMWe = 0; expMMode = '0; expMAddr = '0; expMWdata = '0;
            expFRd = '0; expDRd = '0; expBusy = 0; expErr = 0;
        end else begin
            if (owner == 0 && rv) expErr = 1'b1;
            if (owner != 0) begin
                waitCnt++;
                if (rv || waitCnt == int'(TIMEOUT)) begin
                    if (!rv) expErr = 1'b1;
                    if (owner == 1) begin
                        expFRv = 1'b1;
                        expFRd = rv ? rd : 32'h0;
                    end else begin
                        expDRv = 1'b1;
                        expDRd = (rv && !ownerWe) ? rd : 32'h0;
                    end
                    owner = 0;
                end
            end
            if (gD) begin
                owner = 2; waitCnt = 0; ownerWe = dW;
                expMReq = 1'b1; expMWe = dW; expMMode = dM; expMAddr = dA; expMWdata = dWd;
                if (fPend && losses < int'(MAX_WAIT)) losses++;
                dPend = 1'b0;
                schedResp();
            end
            if (gF) begin
                owner = 1; waitCnt = 0; losses = 0;
                expMReq = 1'b1; expMWe = 1'b0; expMMode = '0; expMAddr = fA; expMWdata = '0;
                fPend = 1'b0;
                schedResp();
            end
            expBusy = (owner != 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_mode = '0;
        d_addr = '0; d_wdata = '0; m_rvalid = 0; m_rdata = '0;

        // Reset state.
        rstForce = 1'b1;
        run(3);
        rstForce = 1'b0;
        run(2);

        // Single fetch, response one cycle after m_req.
        rdFix = 1'b1; rdVal = 32'h00500093; minDel = 2; maxDel = 2;
        fPend = 1'b1; fA = 32'h40;
        run(6);
        checkEq("single_fetch_rdata", f_rdata, 32'h00500093);
        checkEq("single_fetch_addr", m_addr, 32'h40);
        rdFix = 1'b0;

        // Simultaneous fetch and load: data first, fetch next.
        fPend = 1'b1; fA = 32'h80;
        dPend = 1'b1; dW = 1'b0; dM = 3'b010; dA = 32'h100; dWd = 32'h0;
        fGntCnt = 0; dGntCnt = 0;
        run(10);
        checkEq("simul_fgnt", 32'(fGntCnt), 32'd1);
        checkEq("simul_dgnt", 32'(dGntCnt), 32'd1);

        // Starvation: continuous data and fetch requests.
        minDel = 1; maxDel = 1; dRate = 100; fRate = 100;
        fGntCnt = 0; dGntCnt = 0;
        for (int i = 0; i < 60 && fGntCnt == 0; i++) step();
        checkEq("starve_dgnts", 32'(dGntCnt), 32'(MAX_WAIT));
        checkEq("starve_fgnt", 32'(fGntCnt), 32'd1);
        dGntCnt = 0;
        for (int i = 0; i < 60 && dGntCnt < 5; i++) step();
        checkEq("starve_again_fgnt", 32'(fGntCnt), 32'd2);
        dRate = 0; fRate = 0;
        run(20);

        // Store.
        minDel = 2; maxDel = 2;
        dPend = 1'b1; dW = 1'b1; dM = 3'b010; dA = 32'h20; dWd = 32'hDEADBEEF;
        run(6);
        checkEq("store_rdata", d_rdata, 32'h0);
        checkEq("store_wdata", m_wdata, 32'hDEADBEEF);

        // Timeout on a fetch that never gets a response.
        noResp = 1'b1;
        fPend = 1'b1; fA = 32'h44;
        run(20);
        checkEq("timeout_err", 32'(err), 32'd1);
        checkEq("timeout_rdata", f_rdata, 32'h0);
        noResp = 1'b0;
        run(5);
        checkEq("timeout_err_sticky", 32'(err), 32'd1);

        // Reset mid data wait, late response arrives after reset.
        rstForce = 1'b1; run(1); rstForce = 1'b0; run(1);
        minDel = 3; maxDel = 3;
        dPend = 1'b1; dW = 1'b0; dA = 32'h200;
        run(2);
        rstForce = 1'b1; run(1); rstForce = 1'b0;
        dRvCnt = 0;
        run(2);
        checkEq("late_rv_err", 32'(err), 32'd1);
        checkEq("late_rv_busy", 32'(busy), 32'd0);
        checkEq("late_rv_drvalid", 32'(dRvCnt), 32'd0);

        // Random traffic.
        fRate = 30; dRate = 40; storePct = 40; spurPct = 2; rstPermille = 4;
        minDel = 1; maxDel = 4;
        for (int i = 0; i < 2000; i++) begin
            noResp = ($urandom_range(99, 0) < 3);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
